// File: rtl/wam_pkg.sv
// Shared constants, segment glyphs and converter FSM encoding for the score display.
package wam_pkg;

    localparam int unsigned SCAN_DIV_DEF = 16;
    localparam int unsigned BLANK_DEF    = 2;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low glyphs, bit 0 = segment a; entry N is hex digit N.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StConv = 2'd1,
        StLoad = 2'd2
    } conv_state_e;

endpackage

// File: rtl/wam_b2d.sv
// Sequential binary-to-BCD converter: one double-dabble step per cycle, 12 steps per start.
module wam_b2d (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [9:0] bin,
    output logic       busy,
    output logic       done,
    output logic [3:0] hun,
    output logic [3:0] ten,
    output logic [3:0] one
);

    logic [11:0] sh_q;
    logic [11:0] bcd_q;
    logic [3:0]  cnt_q;
    logic        run_q;
    logic [11:0] adj;

    // Add 3 to every BCD nibble that is 5 or more before the shift.
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Load on start, then shift one binary bit into the BCD register per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            sh_q  <= {2'b00, bin};
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            sh_q  <= {sh_q[10:0], 1'b0};
            bcd_q <= {adj[10:0], sh_q[11]};
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd11) begin
                run_q <= 1'b0;
            end
        end
    end

    assign busy = run_q;
    // High during the cycle whose closing edge performs the final shift.
    assign done = run_q && (cnt_q == 4'd11);
    assign hun  = bcd_q[11:8];
    assign ten  = bcd_q[7:4];
    assign one  = bcd_q[3:0];

endmodule

// File: rtl/wam_scn.sv
// Score/hardness 4-digit multiplexed 7-segment driver with saturating BCD conversion.
module wam_scn
    import wam_pkg::*;
#(
    parameter int unsigned SCAN_DIV = SCAN_DIV_DEF,
    parameter int unsigned BLANK    = BLANK_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] score,
    input  logic [3:0]  hrdn,
    input  logic        lstn,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic        busy
);

    localparam int unsigned CW        = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] SLOT_MAX  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK);

    conv_state_e state_q, state_d;
    logic [11:0] last_q;
    logic [3:0]  hun_q, ten_q, one_q;
    logic        start;
    logic [9:0]  sat_val;
    logic        b2d_busy, b2d_done;
    logic [3:0]  b2d_hun, b2d_ten, b2d_one;

    logic [CW-1:0] slot_q;
    logic [1:0]    dig_q;
    logic [3:0]    an_d;
    logic [6:0]    seg_d;
    logic          dp_d;

    assign sat_val = (score > 12'd999) ? 10'd999 : score[9:0];

    wam_b2d u_b2d (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (sat_val),
        .busy  (b2d_busy),
        .done  (b2d_done),
        .hun   (b2d_hun),
        .ten   (b2d_ten),
        .one   (b2d_one)
    );

    // Conversion FSM next state: start on a changed score, wait for the converter, then load.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (score != last_q) begin
                    start   = 1'b1;
                    state_d = StConv;
                end
            end
            StConv: begin
                if (b2d_done) begin
                    state_d = StLoad;
                end else if (!b2d_busy) begin
                    state_d = StIdle;
                end
            end
            StLoad:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM state, last converted raw score and the display digits (updated only in LOAD).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            last_q  <= '0;
            hun_q   <= '0;
            ten_q   <= '0;
            one_q   <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                last_q <= score;
            end
            if (state_q == StLoad) begin
                hun_q <= b2d_hun;
                ten_q <= b2d_ten;
                one_q <= b2d_one;
            end
        end
    end

    assign busy = (state_q != StIdle);

    // Slot counter and digit index; the index advances when the slot counter wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
            dig_q  <= '0;
        end else if (slot_q == SLOT_MAX) begin
            slot_q <= '0;
            dig_q  <= dig_q + 2'd1;
        end else begin
            slot_q <= slot_q + 1'b1;
        end
    end

    // Digit select and glyph decode with leading-zero blanking.
    always_comb begin
        an_d  = 4'hF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (slot_q >= BLANK_END) begin
            an_d = ~(4'b0001 << dig_q);
            unique case (dig_q)
                2'd0: seg_d = SEG_HEX[one_q];
                2'd1: seg_d = (hun_q == 4'd0 && ten_q == 4'd0) ? SEG_OFF : SEG_HEX[ten_q];
                2'd2: seg_d = (hun_q == 4'd0) ? SEG_OFF : SEG_HEX[hun_q];
                2'd3: begin
                    seg_d = SEG_HEX[hrdn];
                    dp_d  = ~lstn;
                end
                default: seg_d = SEG_OFF;
            endcase
        end
    end

    // Registered display outputs, one cycle behind the scanner state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an   <= 4'hF;
            seg  <= SEG_OFF;
            dp_n <= 1'b1;
        end else begin
            an   <= an_d;
            seg  <= seg_d;
            dp_n <= dp_d;
        end
    end

endmodule

// File: tb/tb_wam_scn.sv
// Scoreboard bench for wam_scn: stimulus queues expected conversions, a monitor checks outputs.
module tb_wam_scn;

    localparam int SD = 8;
    localparam int BL = 2;

    typedef struct {
        int val;
        int fall;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] score = '0;
    logic [3:0]  hrdn  = '0;
    logic        lstn  = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic        busy;

    wam_scn #(
        .SCAN_DIV (SD),
        .BLANK    (BL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .score (score),
        .hrdn  (hrdn),
        .lstn  (lstn),
        .an    (an),
        .seg   (seg),
        .dp_n  (dp_n),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t q[$];
    int   disp_val = 0;
    logic prev_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference scanner: values before the last edge drive the registered outputs.
    int         m_cnt = 0;
    int         m_cnt_p = 0;
    logic [1:0] m_dig = '0;
    logic [1:0] m_dig_p = '0;
    logic [3:0] h_p = '0;
    logic       l_p = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt   <= 0;
            m_cnt_p <= 0;
            m_dig   <= '0;
            m_dig_p <= '0;
        end else begin
            m_cnt_p <= m_cnt;
            m_dig_p <= m_dig;
            h_p     <= hrdn;
            l_p     <= lstn;
            if (m_cnt == SD - 1) begin
                m_cnt <= 0;
                m_dig <= m_dig + 2'd1;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
            4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
            4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
            4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  default: g = 7'h71;
        endcase
        return ~g;
    endfunction

    // Expected {an, seg, dp_n} for a scanner position and displayed value.
    function automatic logic [11:0] exp_scan(input int cnt, input logic [1:0] dig,
                                             input int val, input logic [3:0] h, input logic l);
        int         hu, te, on;
        logic [3:0] a;
        logic [6:0] s;
        logic       d;
        hu = val / 100;
        te = (val / 10) % 10;
        on = val % 10;
        if (cnt < BL) return {4'hF, 7'h7F, 1'b1};
        d = 1'b1;
        case (dig)
            2'd0: begin a = 4'b1110; s = glyph(on[3:0]); end
            2'd1: begin a = 4'b1101; s = (hu == 0 && te == 0) ? 7'h7F : glyph(te[3:0]); end
            2'd2: begin a = 4'b1011; s = (hu == 0) ? 7'h7F : glyph(hu[3:0]); end
            default: begin a = 4'b0111; s = glyph(h); d = ~l; end
        endcase
        return {a, s, d};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: per-cycle scan/invariant checks; pop an expectation on each busy fall.
    always @(negedge clk) begin : mon
        logic [11:0] e;
        exp_t        it;
        if (!rst_n) begin
            chk("reset_outputs", {an, seg, dp_n, busy}, {4'hF, 7'h7F, 1'b1, 1'b0});
            q.delete();
            disp_val  = 0;
            prev_busy = 1'b0;
        end else begin
            e = exp_scan(m_cnt_p, m_dig_p, disp_val, h_p, l_p);
            chk("scan", {an, seg, dp_n}, e);
            chk("an_onehot", (an == 4'hF || $countones(~an) == 1), 1);
            if (prev_busy && !busy) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_done: got conversion end at cycle %0d expected none",
                             cyc);
                end else begin
                    it = q.pop_front();
                    chk("done_cycle", cyc, it.fall);
                    disp_val = it.val;
                end
            end
            prev_busy = busy;
        end
    end

    task automatic drive(input int v, input int ev, input int lat);
        @(negedge clk);
        score = 12'(v);
        q.push_back('{ev, cyc + lat});
    endtask

    initial begin : stim
        int n_b, n_blank;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        // Zero score after reset: no conversion, ones shows 0, tens/hundreds blank.
        repeat (40) @(negedge clk);
        chk("idle_busy", busy, 0);

        drive(437, 437, 14);
        @(posedge clk);
        #1 chk("busy_rise", busy, 1);
        repeat (50) @(negedge clk);

        drive(1234, 999, 14);
        repeat (50) @(negedge clk);

        drive(5, 5, 14);
        repeat (50) @(negedge clk);

        drive(12, 12, 14);
        repeat (50) @(negedge clk);
        drive(34, 34, 14);
        repeat (2) @(negedge clk);
        drive(56, 56, 25);
        repeat (60) @(negedge clk);

        // Hardness slot with flash request.
        @(negedge clk);
        hrdn = 4'hB;
        lstn = 1'b1;
        repeat (40) @(negedge clk);
        n_b = 0;
        n_blank = 0;
        for (int i = 0; i < 4 * SD; i++) begin
            @(negedge clk);
            if (an == 4'b0111 && seg == 7'h03 && dp_n == 1'b0) n_b++;
            if (an == 4'hF) n_blank++;
        end
        chk("hard_slot_cycles", n_b, SD - BL);
        chk("blank_cycles", n_blank, 4 * BL);

        // Reset in the sixth conversion cycle.
        drive(700, 700, 14);
        repeat (6) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dp", dp_n, 1'b1);
        chk("rst_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        q.push_back('{700, cyc + 14});
        @(posedge clk);
        #1 chk("restart_first_edge", busy, 1);
        repeat (50) @(negedge clk);

        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
